// File: rtl/led_pattern_engine_pkg.sv
// Shared encodings and default step-rate dividers for the LED pattern engine.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'd0,
        MODE_ROR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int unsigned DEF_DIV0 = 50_000_000;
    localparam int unsigned DEF_DIV1 = 25_000_000;
    localparam int unsigned DEF_DIV2 = 12_500_000;
    localparam int unsigned DEF_DIV3 = 6_250_000;

    // Prescaler width: enough bits to count 0..max(DIVn)-1, never less than one bit.
    function automatic int unsigned presc_width(input int unsigned d0, input int unsigned d1,
                                                input int unsigned d2, input int unsigned d3);
        int unsigned m;
        int unsigned w;
        m = d0;
        if (d1 > m) m = d1;
        if (d2 > m) m = d2;
        if (d3 > m) m = d3;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control inputs and LED outputs of the pattern engine, grouped as one bus.
interface led_pattern_engine_if #(
    parameter int unsigned LED_W = 8
);
    logic             button;
    logic [1:0]       freq_set;
    logic [1:0]       mode;
    logic [LED_W-1:0] led;
    logic             running;

    modport master (
        output button, freq_set, mode,
        input  led, running
    );

    modport slave (
        input  button, freq_set, mode,
        output led, running
    );
endinterface

// File: rtl/led_pattern_engine_btn_sync_edge.sv
// Two-flop synchroniser for the raw push-button plus a one-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic toggle_c
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic [2:0] vld_q, vld_d;

    // vld marks when sync/prev hold real samples, so reset zeros never look like a press
    always_comb begin
        sync_d   = {sync_q[0], button};
        prev_d   = sync_q[1];
        vld_d    = {vld_q[1:0], 1'b1};
        toggle_c = sync_q[1] & ~prev_q & vld_q[2];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            vld_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: run/pause FSM, selectable-rate prescaler and four LED patterns.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int unsigned LED_W = 8,
    parameter int unsigned DIV0  = DEF_DIV0,
    parameter int unsigned DIV1  = DEF_DIV1,
    parameter int unsigned DIV2  = DEF_DIV2,
    parameter int unsigned DIV3  = DEF_DIV3
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pattern_engine_if.slave  bus
);

    localparam int unsigned PW = presc_width(DIV0, DIV1, DIV2, DIV3);
    localparam logic [PW-1:0] LAST0 = PW'(DIV0 - 1);
    localparam logic [PW-1:0] LAST1 = PW'(DIV1 - 1);
    localparam logic [PW-1:0] LAST2 = PW'(DIV2 - 1);
    localparam logic [PW-1:0] LAST3 = PW'(DIV3 - 1);
    localparam logic [LED_W-1:0] INIT_LOW  = LED_W'(1);
    localparam logic [LED_W-1:0] INIT_HIGH = {1'b1, {(LED_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic             running_q, running_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             dir_up_q, dir_up_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [1:0]       freq_q, freq_d;
    mode_e            mode_q, mode_d;

    logic             toggle_c;
    logic             freq_chg_c;
    logic             mode_chg_c;
    logic             tick_c;
    logic [PW-1:0]    last_c;
    logic [LED_W-1:0] step_led_c;
    logic             step_dir_c;

    btn_sync_edge u_btn (
        .clk      (clk),
        .rst      (rst),
        .button   (bus.button),
        .toggle_c (toggle_c)
    );

    // Next-state: FSM, prescaler, pattern step and mode reload
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        dir_up_d   = dir_up_q;
        presc_d    = presc_q;
        freq_d     = bus.freq_set;
        mode_d     = mode_e'(bus.mode);
        freq_chg_c = (bus.freq_set != freq_q);
        mode_chg_c = (mode_d != mode_q);
        tick_c     = 1'b0;
        step_led_c = led_q;
        step_dir_c = dir_up_q;

        case (freq_q)
            2'd0:    last_c = LAST0;
            2'd1:    last_c = LAST1;
            2'd2:    last_c = LAST2;
            default: last_c = LAST3;
        endcase

        // A rate or mode change restarts the count and swallows any tick due this cycle
        if (state_q == ST_RUN) begin
            if (freq_chg_c || mode_chg_c) begin
                presc_d = '0;
            end else if (presc_q == last_c) begin
                presc_d = '0;
                tick_c  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = '0;
        end

        case (mode_q)
            MODE_ROL:    step_led_c = {led_q[LED_W-2:0], led_q[LED_W-1]};
            MODE_ROR:    step_led_c = {led_q[0], led_q[LED_W-1:1]};
            MODE_BOUNCE: begin
                if (dir_up_q) begin
                    if (led_q[LED_W-1]) begin
                        step_dir_c = 1'b0;
                        step_led_c = led_q >> 1;
                    end else begin
                        step_led_c = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        step_dir_c = 1'b1;
                        step_led_c = led_q << 1;
                    end else begin
                        step_led_c = led_q >> 1;
                    end
                end
            end
            default:     step_led_c = (&led_q) ? '0 : ((led_q << 1) | INIT_LOW);
        endcase

        if (mode_chg_c) begin
            led_d    = (mode_d == MODE_ROR) ? INIT_HIGH : INIT_LOW;
            dir_up_d = 1'b1;
        end else if (tick_c) begin
            led_d    = step_led_c;
            dir_up_d = step_dir_c;
        end

        if (toggle_c) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
            led_q     <= INIT_LOW;
            dir_up_q  <= 1'b1;
            presc_q   <= '0;
            freq_q    <= bus.freq_set;
            mode_q    <= mode_e'(bus.mode);
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            led_q     <= led_d;
            dir_up_q  <= dir_up_d;
            presc_q   <= presc_d;
            freq_q    <= freq_d;
            mode_q    <= mode_d;
        end
    end

    assign bus.led     = led_q;
    assign bus.running = running_q;

endmodule
